// File: rtl/stop_watch_pkg.sv
// Shared BCD constants and helpers for the stopwatch/timer core.
package stop_watch_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    // Clamp an arbitrary nibble into the legal BCD range 0..9.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/stop_watch_lap_bcd_digit.sv
// One BCD digit of the stopwatch count: up/down step with ripple carry/borrow,
// synchronous clear and saturating load.
module bcd_digit
    import stop_watch_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             en,
    input  logic             down,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic [BCD_W-1:0] r_q;
    logic             w_at_limit;

    // The digit wraps (and passes a carry/borrow on) when it sits at the end
    // of its range in the current count direction.
    assign w_at_limit = down ? (r_q == BCD_MIN) : (r_q == BCD_MAX);
    assign cout       = en & w_at_limit;
    assign q          = r_q;

    // Digit register: clear beats load beats step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= BCD_MIN;
        end else if (clr) begin
            r_q <= BCD_MIN;
        end else if (load) begin
            r_q <= bcd_sat(load_val);
        end else if (en) begin
            if (down) begin
                r_q <= w_at_limit ? BCD_MAX : (r_q - 4'd1);
            end else begin
                r_q <= w_at_limit ? BCD_MIN : (r_q + 4'd1);
            end
        end
    end

endmodule

// File: rtl/stop_watch_lap.sv
// N-digit BCD stopwatch / countdown timer with tick prescaler, preset load,
// lap freeze of the displayed value, sticky overflow and one-shot done.
module stop_watch_lap
    import stop_watch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    go,
    input  logic                    clr,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] preset,
    input  logic                    down,
    input  logic                    lap,
    output logic [BCD_W*DIGITS-1:0] digits,
    output logic                    lap_active,
    output logic                    ovf,
    output logic                    done,
    output logic                    tick
);

    localparam int                    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BCD_W*DIGITS-1:0] COUNT_ONE = (BCD_W*DIGITS)'(1);

    logic [PW-1:0]             r_presc;
    logic [BCD_W*DIGITS-1:0]   r_latch;
    logic                      r_lap_active;
    logic                      r_ovf;
    logic                      r_done;

    logic                      w_tick;
    logic                      w_step;
    logic                      w_zero;
    logic [BCD_W*DIGITS-1:0]   w_count;
    logic [DIGITS:0]           w_carry;

    assign w_tick = go & (r_presc == PRESC_LAST);
    assign w_zero = (w_count == '0);
    // A tick only steps the count when no clear/load claims the cycle, and a
    // countdown parked at zero stays there.
    assign w_step     = w_tick & ~clr & ~load & ~(down & w_zero);
    assign w_carry[0] = w_step;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .reset_n  (reset_n),
                .clr      (clr),
                .load     (load),
                .load_val (preset[gi*BCD_W +: BCD_W]),
                .en       (w_carry[gi]),
                .down     (down),
                .q        (w_count[gi*BCD_W +: BCD_W]),
                .cout     (w_carry[gi+1])
            );
        end
    endgenerate

    // Prescaler: free-runs while go is high, holds while paused so a resumed
    // interval finishes where it left off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (clr || load) begin
            r_presc <= '0;
        end else if (go) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : (r_presc + PW'(1));
        end
    end

    // Flags: sticky overflow on an up-count wrap of the top digit, done pulses
    // on the step that lands a countdown on zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_step & down & (w_count == COUNT_ONE);
            if (clr || load) begin
                r_ovf <= 1'b0;
            end else if (w_step && !down && w_carry[DIGITS]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Lap freeze: first press captures the pre-update count, second releases.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_latch      <= '0;
            r_lap_active <= 1'b0;
        end else if (clr) begin
            r_lap_active <= 1'b0;
        end else if (lap) begin
            if (!r_lap_active) begin
                r_latch      <= w_count;
                r_lap_active <= 1'b1;
            end else begin
                r_lap_active <= 1'b0;
            end
        end
    end

    assign digits     = r_lap_active ? r_latch : w_count;
    assign lap_active = r_lap_active;
    assign ovf        = r_ovf;
    assign done       = r_done;
    assign tick       = w_tick;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Directed bench for stop_watch_lap with DIGITS=3, TICK_DIV=4.
module tb_stop_watch_lap;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go, clr, load, down, lap;
    logic [11:0] preset;
    logic [11:0] digits;
    logic        lap_active, ovf, done, tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stop_watch_lap #(.DIGITS(3), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .clr        (clr),
        .load       (load),
        .preset     (preset),
        .down       (down),
        .lap        (lap),
        .digits     (digits),
        .lap_active (lap_active),
        .ovf        (ovf),
        .done       (done),
        .tick       (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; go = 1'b1; clr = 1'b0; load = 1'b0;
        down = 1'b0; lap = 1'b0; preset = 12'h000;

        // 1. reset with go high, then free count
        cyc(3);
        chk("rst_digits", 32'(digits), 32'h000);
        chk("rst_lap", 32'(lap_active), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        reset_n = 1'b1;
        cyc(3);
        chk("s1_tick_on", 32'(tick), 32'd1);
        cyc(1);
        chk("s1_first_step", 32'(digits), 32'h001);
        chk("s1_tick_off", 32'(tick), 32'd0);
        cyc(36);
        chk("s1_40cyc", 32'(digits), 32'h010);
        chk("s1_ovf", 32'(ovf), 32'd0);

        // 2. up-count wrap sets sticky ovf
        load = 1'b1; preset = 12'h999;
        cyc(1);
        load = 1'b0;
        chk("s2_loaded", 32'(digits), 32'h999);
        cyc(4);
        chk("s2_wrap", 32'(digits), 32'h000);
        chk("s2_ovf_set", 32'(ovf), 32'd1);
        cyc(20);
        chk("s2_ovf_sticky", 32'(ovf), 32'd1);
        chk("s2_after20", 32'(digits), 32'h005);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("s2_clr_ovf", 32'(ovf), 32'd0);
        chk("s2_clr_digits", 32'(digits), 32'h000);

        // 3. countdown to zero with one-shot done
        load = 1'b1; preset = 12'h002; down = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("s3_001", 32'(digits), 32'h001);
        chk("s3_done_early", 32'(done), 32'd0);
        cyc(4);
        chk("s3_000", 32'(digits), 32'h000);
        chk("s3_done_pulse", 32'(done), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("s3_done_hold", 32'(done), 32'd0);
        end
        chk("s3_zero_hold", 32'(digits), 32'h000);

        // 4. lap freeze while counting continues
        down = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(60);
        chk("s4_015", 32'(digits), 32'h015);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("s4_lap_on", 32'(lap_active), 32'd1);
        chk("s4_frozen", 32'(digits), 32'h015);
        cyc(19);
        chk("s4_still_frozen", 32'(digits), 32'h015);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("s4_lap_off", 32'(lap_active), 32'd0);
        chk("s4_020", 32'(digits), 32'h020);

        // 5. pause holds the prescaler phase
        go = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0; go = 1'b1;
        cyc(2);
        go = 1'b0;
        cyc(10);
        chk("s5_paused_digits", 32'(digits), 32'h000);
        go = 1'b1;
        #0;
        chk("s5_no_tick_yet", 32'(tick), 32'd0);
        cyc(1);
        chk("s5_tick", 32'(tick), 32'd1);
        cyc(1);
        chk("s5_001", 32'(digits), 32'h001);

        // 6. clr beats load, clr forces lap off; load saturates bad nibbles
        go = 1'b0; lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        chk("s6_lap_on", 32'(lap_active), 32'd1);
        clr = 1'b1; load = 1'b1; lap = 1'b1; preset = 12'hC05;
        cyc(1);
        clr = 1'b0; load = 1'b0; lap = 1'b0;
        chk("s6_clr_digits", 32'(digits), 32'h000);
        chk("s6_clr_lap", 32'(lap_active), 32'd0);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("s6_sat_load", 32'(digits), 32'h905);

        // Reset mid-lap clears the freeze and the count
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        chk("rst_mid_lap", 32'(lap_active), 32'd0);
        chk("rst_mid_digits", 32'(digits), 32'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stop_watch_lap.md
Name: stop_watch_lap

Overview:
Parametrised N-digit BCD stopwatch/timer core with its own tick prescaler. Supports up-count (stopwatch) or down-count (countdown timer), preset load, a lap/split freeze of the displayed value, and sticky overflow and done flags. It drives the hex display multiplexer's digit inputs, and it takes debounced, single-cycle pushbutton pulses from the board-level top.

Parameters:
DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
TICK_DIV, 5_000_000, clk cycles per count tick (>=2); the default gives 0.1 s at 50 MHz.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  synchronous, active-low reset.
go  in  1  level input; 1 = run, 0 = pause (prescaler and count hold).
clr  in  1  pulse; clears count, prescaler and flags.
load  in  1  pulse; loads preset into count.
preset  in  4*DIGITS  BCD preset value; nibble i is digit i.
down  in  1  level input; 0 = count up, 1 = count down.
lap  in  1  pulse; toggles the lap freeze.
digits  out  4*DIGITS  displayed BCD value.
lap_active  out  1  1 while the display is frozen.
ovf  out  1  sticky up-count wrap flag.
done  out  1  one-cycle pulse when a down-count reaches zero.
tick  out  1  strobe in the cycle a count step is taken.

Behaviour:
- Reset (reset_n=0 at an edge): prescaler=0, count=0, latch=0, lap_active=0, ovf=0, done=0. Reset overrides every input, including a reset asserted mid-count or mid-lap.
- Priority per cycle: reset_n > clr > load > tick step. lap is evaluated independently, except that clr forces lap_active=0.
- Prescaler:
  - When go=1, it counts 0..TICK_DIV-1 and wraps to 0.
  - When go=0, it holds its value. Resuming go completes the remaining cycles of the interval.
  - tick = go & (prescaler==TICK_DIV-1). tick is combinational and coincides with the edge on which count updates.
- clr: count=0, prescaler=0, ovf=0, done=0, lap_active=0.
- load:
  - count=preset, prescaler=0, ovf=0.
  - Any preset nibble >9 is loaded as 9.
  - A tick in the same cycle is discarded.
- Up step (down=0):
  - BCD increment with a ripple carry; each digit wraps 9->0 and carries into the next digit.
  - All digits at 9 wraps to all 0 and sets ovf=1. ovf stays set until clr, load or reset.
- Down step (down=1):
  - BCD decrement with a borrow; each digit wraps 0->9 and borrows from the next digit.
  - A step that makes count all-zero asserts done for exactly that following cycle.
  - While count is zero, down ticks are ignored: count holds 0 and done does not re-assert. There is no ovf in down mode.
- down may change at any time; it takes effect on the next tick.
- lap:
  - With lap_active=0: latch <= current count register (pre-update value), lap_active <= 1.
  - With lap_active=1: lap_active <= 0.
  - Counting continues underneath the freeze.
- digits = lap_active ? latch : count. This is a combinational mux of registers, so an update is visible in the cycle after the updating edge.
- Outputs are never X after reset; all values stay in the range 0..9 per nibble.

Decomposition:
- Package stop_watch_pkg: BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0, and a function bcd_sat(nibble) that clamps a nibble to 9.
- Sub-module bcd_digit: one-digit register with up/down, enable-in, carry/borrow-out, synchronous clear and load. It is instantiated DIGITS times via generate, with the carry chain between instances.
- Top level: prescaler, control priority, lap latch, flags.

Test Plan:
All scenarios use DIGITS=3, TICK_DIV=4.
1. Hold reset_n=0 with go=1 for 3 cycles -> digits=000, all flags 0. Release, go=1 -> tick every 4th cycle; after 40 cycles digits=010, ovf=0.
2. load preset=999, down=0, go=1 -> after one tick digits=000, ovf=1; ovf stays 1 over 20 more cycles; clr -> ovf=0, digits=000.
3. load preset=002, down=1, go=1 -> digits go 001 then 000, with done=1 for one cycle; over 12 further cycles digits=000 and done stays 0.
4. Count up to 015, pulse lap -> digits frozen at 015, lap_active=1. After 5 more ticks, a second lap -> digits=020, lap_active=0.
5. go=1 for 2 cycles, go=0 for 10 cycles, go=1 -> tick occurs after exactly 2 further cycles; digits=001.
6. With lap_active=1, assert clr, load and lap in the same cycle with preset=0xC05 -> digits=000, lap_active=0. Then load alone -> digits=905.
